fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined successor to the single-cycle core.
- Owns the PC, issues requests to a variable-latency instruction memory, and buffers returned instructions in an in-order queue for decode.
- Handles branch/BR redirects with flush and drop of in-flight responses.
- Stops fetching after HLT, so the PC freezes as the ISA requires.

Parameters:
- ADDR_W, 16, PC and memory address width
- INSTR_W, 16, instruction width
- QDEPTH, 4, instruction queue entries (power of 2, >=2)
- PC_STEP, 2, byte increment per sequential fetch
- HLT_OP, 4'hF, opcode value (instr[INSTR_W-1 -: 4]) marking HLT

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (in order, latency >=1 after grant)
- imem_rdata  in  INSTR_W  response instruction
- inst_valid  out  1  queue head valid to decode
- inst_ready  in  1  decode accepts head
- inst_data  out  INSTR_W  head instruction
- inst_pc  out  ADDR_W  head instruction address
- inst_npc  out  ADDR_W  head PC + PC_STEP (for PCS and B target base)
- redirect_valid  in  1  taken branch/BR from execute
- redirect_pc  in  ADDR_W  new fetch target
- hlt  out  1  registered; HLT has been consumed by decode
- pc  out  ADDR_W  current fetch PC

Behaviour:
- Reset (async, rst_n low) clears all state.
  - pc=0, queue empty, outstanding=0, drop=0, halt_seen=0, hlt=0.
  - imem_req=0, inst_valid=0.
- Reset mid-transfer discards everything. Responses arriving after reset release with outstanding=0 are ignored.
- Credit: imem_req = !redirect_valid && !halt_seen && (count + outstanding < QDEPTH).
- imem_addr = pc.
- On imem_req && imem_gnt:
  - pc <= pc + PC_STEP, modulo 2^ADDR_W (0xFFFE wraps to 0x0000).
  - outstanding++.
  - The issued address is pushed into a side pc-FIFO, so PC tags stay aligned with responses.
- On imem_rvalid:
  - If drop>0: drop--, outstanding--, response discarded.
  - Otherwise: enqueue {rdata, tag pc}, outstanding--.
  - If opcode==HLT_OP, set halt_seen. No further requests are issued.
- Credit rule guarantees the queue never overflows. rvalid with outstanding==0 is a protocol error; assert in simulation, ignore in RTL.
- Decode handshake:
  - Pop when inst_valid && inst_ready. inst_* reflect the head combinationally from queue registers.
  - Simultaneous push and pop are allowed in the same cycle. On a full queue, the pop frees space for the next cycle only.
- Popping an entry whose opcode==HLT_OP sets hlt=1 the following cycle, sticky until reset or redirect.
- Redirect has highest priority in its cycle:
  - pc <= redirect_pc. Queue and pc-FIFO flushed. halt_seen<=0, hlt<=0.
  - drop <= outstanding minus any response dropped or consumed that same cycle. A response arriving in the redirect cycle is discarded.
  - No request is issued and no pop occurs that cycle (inst_valid forced 0).
  - First request to redirect_pc is issued the next cycle.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Latency: zero-wait memory (gnt=1, rvalid one cycle after grant) gives the first inst_valid 2 cycles after reset release. Sustained throughput is 1 instruction per cycle with QDEPTH>=2.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_stall_cyc[31:0] and perf_flush_cnt[15:0], both cleared by reset.
  - perf_stall_cyc counts cycles with inst_ready=1 and inst_valid=0 and no redirect.
  - perf_flush_cnt counts redirect cycles. Both saturate at max.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_HLT=4'hF, OP_B, OP_BR, OP_PCS)
  - default ADDR_W/INSTR_W
  - typedef fetch_entry_t {instr, pc}
- One sub-module: fetch_queue, a synchronous FIFO with DEPTH and WIDTH parameters.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Instantiated twice: instruction queue, and pc-tag FIFO (depth QDEPTH).

Test Plan:
1. Zero-wait memory, imem program 0x1000,0x2000,... ready=1 -> inst_pc 0,2,4,6 on consecutive cycles; first inst_valid at cycle 2; pc advances 2 per cycle.
2. inst_ready=0 with QDEPTH=4 -> exactly 4 grants, then imem_req=0 and pc=0x0008. Raise ready -> 1 instruction per cycle resumes, no loss or duplication.
3. Memory latency 3, redirect_pc=0x0040 with 2 requests outstanding -> both late responses dropped; next inst_pc=0x0040; inst_valid=0 in the redirect cycle.
4. Instruction 0xF000 at address 0x000A -> no request after its response. Decode pops it -> hlt=1 next cycle; pc stays at 0x000C or the last issued value +2 and is frozen.
5. HLT enqueued, then redirect to 0x0100 before it is popped -> hlt stays 0, fetch resumes at 0x0100.
6. Redirect to 0xFFFE -> fetches 0xFFFE then 0x0000 (wrap); rst_n pulsed low mid-latency -> all outputs at reset values, pc=0, stale response ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined core: default widths, opcodes and the
// fetch queue entry layout handed to decode.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 16;
    localparam int CPU_INSTR_W = 16;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic [CPU_INSTR_W-1:0] instr;
        logic [CPU_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO used for both the instruction queue and the pc-tag FIFO.
// Flush empties it in one cycle; a pop on a full queue frees space for the next cycle only.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CPU_INSTR_W + CPU_ADDR_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited requests, tags and queues
// responses for decode, handles redirects and HLT. Optional perf counters: FETCH_PERF_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int         ADDR_W  = CPU_ADDR_W,
    parameter int         INSTR_W = CPU_INSTR_W,
    parameter int         QDEPTH  = 4,
    parameter int         PC_STEP = 2,
    parameter logic [3:0] HLT_OP  = OP_HLT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic [ADDR_W-1:0]  inst_npc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               hlt,
    output logic [ADDR_W-1:0]  pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cyc,
    output logic [15:0]        perf_flush_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic              halt_seen_q, halt_seen_d;
    logic              hlt_q, hlt_d;

    logic [CW-1:0]     iq_count, tq_count;
    logic              iq_full, iq_empty, tq_full, tq_empty;
    entry_t            iq_din, iq_dout;
    logic [ADDR_W-1:0] tq_dout;
    logic [CW-1:0]     drop;
    logic              grant, rsp_seen, rsp_take, pop;

    // Every live request owns a tag; outstanding requests without a tag predate a redirect.
    assign drop = outst_q - tq_count;

    assign imem_req = rst_n && !redirect_valid && !halt_seen_q && !iq_full && !tq_full &&
                      ((int'(iq_count) + int'(outst_q)) < QDEPTH);
    assign grant    = imem_req && imem_gnt;

    // A response with nothing outstanding (e.g. stale after reset) is ignored entirely.
    assign rsp_seen = imem_rvalid && (outst_q != '0);
    assign rsp_take = imem_rvalid && (drop == '0) && !tq_empty && !redirect_valid;

    assign inst_valid = !iq_empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    assign iq_din.instr = imem_rdata;
    assign iq_din.pc    = tq_dout;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(entry_t))
    ) u_inst_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_take),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (iq_din),
        .dout  (iq_dout),
        .count (iq_count),
        .full  (iq_full),
        .empty (iq_empty)
    );

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ADDR_W)
    ) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .pop   (rsp_take),
        .flush (redirect_valid),
        .din   (pc_q),
        .dout  (tq_dout),
        .count (tq_count),
        .full  (tq_full),
        .empty (tq_empty)
    );

    always_comb begin
        pc_d        = pc_q;
        outst_d     = outst_q;
        halt_seen_d = halt_seen_q;
        hlt_d       = hlt_q;
        if (grant) begin
            outst_d = outst_d + CW'(1);
        end
        if (rsp_seen) begin
            outst_d = outst_d - CW'(1);
        end
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            halt_seen_d = 1'b0;
            hlt_d       = 1'b0;
        end else begin
            if (grant) begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end
            if (rsp_take && (imem_rdata[INSTR_W-1 -: 4] == HLT_OP)) begin
                halt_seen_d = 1'b1;
            end
            if (pop && (iq_dout.instr[INSTR_W-1 -: 4] == HLT_OP)) begin
                hlt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            outst_q     <= '0;
            halt_seen_q <= 1'b0;
            hlt_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            outst_q     <= outst_d;
            halt_seen_q <= halt_seen_d;
            hlt_q       <= hlt_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign hlt       = hlt_q;
    assign inst_data = iq_dout.instr;
    assign inst_pc   = iq_dout.pc;
    assign inst_npc  = iq_dout.pc + ADDR_W'(PC_STEP);

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (inst_ready && !inst_valid && !redirect_valid && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (redirect_valid && (flush_q != '1)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign perf_stall_cyc = stall_q;
    assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: epoch-based reference model of the fetch stream plus an in-order
// memory model with configurable latency, driven through directed steps then random traffic.
module tb_fetch_unit;

    localparam int QDEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic [15:0] inst_npc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        hlt;
    logic [15:0] pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [15:0] perf_flush_cnt;
`endif

    fetch_unit #(
        .ADDR_W  (16),
        .INSTR_W (16),
        .QDEPTH  (QDEPTH),
        .PC_STEP (2),
        .HLT_OP  (4'hF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_npc       (inst_npc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hlt            (hlt),
        .pc             (pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model: in-order responses, each tagged with the redirect epoch it was issued in
    typedef struct {
        int          due;
        logic [15:0] data;
        logic [15:0] addr;
        int          epoch;
    } pend_t;
    pend_t       pend[$];
    logic [31:0] exp_q[$];    // {instr, pc} decode should see, oldest first

    logic [15:0] m_pc;
    int          m_epoch, m_cyc, last_due;
    bit          m_halt_seen, m_hlt;
    int          m_stall, m_flush;

    int          lat_min, lat_max;
    bit          gnt_rand, rdy, redir, stale_inject, hlt_en;
    logic [15:0] rpc, hlt_addr;

    logic        s_req, s_valid, s_hlt;
    logic [15:0] s_pc, s_ipc;
    int          grants_seen, first_valid_cyc;
    logic [15:0] g_addr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] instr_at(input logic [15:0] a);
        if (hlt_en && (a == hlt_addr)) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    // One clock cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic run_cycle();
        logic [31:0] head;
        bit          exp_req, exp_valid, got_rsp;
        pend_t       r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        imem_gnt       = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        got_rsp        = (pend.size() > 0) && (pend[0].due == m_cyc);
        if (got_rsp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].data;
        end else if (stale_inject) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hF0A5;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end

        @(negedge clk);
        exp_req   = !redir && !m_halt_seen && ((exp_q.size() + pend.size()) < QDEPTH);
        exp_valid = !redir && (exp_q.size() > 0);
        s_req     = imem_req;
        s_valid   = inst_valid;
        s_hlt     = hlt;
        s_pc      = pc;
        s_ipc     = inst_pc;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("pc", 32'(pc), 32'(m_pc));
        check("inst_valid", 32'(inst_valid), 32'(exp_valid));
        check("hlt", 32'(hlt), 32'(m_hlt));
        if (exp_valid) begin
            head = exp_q[0];
            check("inst_data", 32'(inst_data), 32'(head[31:16]));
            check("inst_pc", 32'(inst_pc), 32'(head[15:0]));
            check("inst_npc", 32'(inst_npc), 32'(16'(head[15:0] + 16'd2)));
        end
        if (imem_req && imem_gnt) begin
            grants_seen++;
            g_addr.push_back(imem_addr);
        end
        if (inst_valid && (first_valid_cyc < 0)) first_valid_cyc = m_cyc;

        if (rdy && !exp_valid && !redir) m_stall++;
        if (redir) m_flush++;
        if (exp_valid && rdy) begin
            head = exp_q.pop_front();
            if (head[31:28] == 4'hF) m_hlt = 1'b1;
        end
        if (got_rsp) begin
            r = pend.pop_front();
            if (!redir && (r.epoch == m_epoch)) begin
                exp_q.push_back({r.data, r.addr});
                if (r.data[15:12] == 4'hF) m_halt_seen = 1'b1;
            end
        end
        if (redir) begin
            m_epoch++;
            exp_q.delete();
            m_halt_seen = 1'b0;
            m_hlt       = 1'b0;
            m_pc        = rpc;
        end else if (exp_req && imem_gnt) begin
            r.due = m_cyc + int'($urandom_range(lat_min, lat_max));
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            r.data   = instr_at(m_pc);
            r.addr   = m_pc;
            r.epoch  = m_epoch;
            pend.push_back(r);
            m_pc = m_pc + 16'd2;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic run_until_valid(input string tag, input int budget);
        int n = 0;
        do begin
            run_cycle();
            n++;
        end while (!s_valid && (n < budget));
        check({tag, "_timeout"}, 32'(s_valid), 32'd1);
    endtask

    // Async reset: assert away from the clock edge, check reset values, release one cycle later.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        pend.delete();
        exp_q.delete();
        g_addr.delete();
        m_pc = '0; m_epoch = 0; m_halt_seen = 1'b0; m_hlt = 1'b0; last_due = -1;
        m_stall = 0; m_flush = 0;
        redir = 1'b0; rpc = '0; stale_inject = 1'b0;
        grants_seen = 0; first_valid_cyc = -1;
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_hlt", 32'(hlt), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cyc = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1; rdy = 1'b1; hlt_en = 1'b0; hlt_addr = '0;

        // zero-wait streaming
        do_reset();
        rdy = 1'b1;
        run_n(8);
        check("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd2);
        check("t1_pc_after_8", 32'(s_pc), 32'h000E);
        run_n(1);
        check("t1_pc_after_9", 32'(s_pc), 32'h0010);

        // credit stall with decode blocked, then resume
        do_reset();
        rdy = 1'b0;
        run_n(8);
        check("t2_grants", 32'(grants_seen), 32'd4);
        check("t2_req_stalled", 32'(s_req), 32'd0);
        check("t2_pc", 32'(s_pc), 32'h0008);
        rdy = 1'b1;
        run_n(12);

        // redirect with two requests in flight at latency 3
        do_reset();
        lat_min = 3; lat_max = 3; rdy = 1'b1;
        for (int i = 0; i < 20 && pend.size() != 2; i++) run_cycle();
        redir = 1'b1; rpc = 16'h0040;
        run_cycle();
        check("t3_valid_in_redirect", 32'(s_valid), 32'd0);
        redir = 1'b0;
        run_until_valid("t3_wait", 20);
        check("t3_first_pc", 32'(s_ipc), 32'h0040);
        redir = 1'b1; rpc = 16'h0060;
        run_cycle();
        rpc = 16'h0070;
        run_cycle();
        redir = 1'b0;
        run_until_valid("t3b_wait", 20);
        check("t3b_first_pc", 32'(s_ipc), 32'h0070);
        run_n(6);

        // HLT at 0x000A stops fetch and raises hlt after decode consumes it
        do_reset();
        lat_min = 1; lat_max = 1; rdy = 1'b1; hlt_en = 1'b1; hlt_addr = 16'h000A;
        run_n(12);
        check("t4_pc_frozen", 32'(s_pc), 32'h000E);
        run_n(5);
        check("t4_pc_still", 32'(s_pc), 32'h000E);
        check("t4_req_off", 32'(s_req), 32'd0);
        check("t4_hlt", 32'(s_hlt), 32'd1);

        // HLT queued but redirected away before decode takes it
        do_reset();
        hlt_addr = 16'h0002; rdy = 1'b0;
        run_n(6);
        check("t5_req_off", 32'(s_req), 32'd0);
        check("t5_queued", 32'(s_valid), 32'd1);
        redir = 1'b1; rpc = 16'h0100;
        run_cycle();
        redir = 1'b0; rdy = 1'b1;
        run_until_valid("t5_wait", 20);
        check("t5_first_pc", 32'(s_ipc), 32'h0100);
        run_n(8);
        check("t5_hlt", 32'(s_hlt), 32'd0);
        hlt_en = 1'b0;

        // address wrap, then reset mid-latency and a stale response
        do_reset();
        redir = 1'b1; rpc = 16'hFFFE;
        run_cycle();
        redir = 1'b0;
        g_addr.delete();
        run_n(4);
        check("t6_grant_count", 32'(g_addr.size() >= 2), 32'd1);
        if (g_addr.size() >= 2) begin
            check("t6_grant0", 32'(g_addr[0]), 32'hFFFE);
            check("t6_grant1", 32'(g_addr[1]), 32'h0000);
        end
        lat_min = 3; lat_max = 3;
        run_n(2);
        do_reset();
        lat_min = 1; lat_max = 1;
        stale_inject = 1'b1;
        run_cycle();
        stale_inject = 1'b0;
        run_n(8);

        // random traffic: grant gaps, variable latency, decode backpressure, redirects, HLTs
        do_reset();
        gnt_rand = 1'b1; lat_min = 1; lat_max = 4; hlt_en = 1'b1; hlt_addr = 16'h0020;
        for (int i = 0; i < 600; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) rpc = 16'($urandom_range(0, 24)) << 1;
            else rpc = 16'($urandom) & 16'hFFFE;
            run_cycle();
        end
        redir = 1'b0;
        run_n(10);
`ifdef FETCH_PERF_EN
        check("perf_stall_cyc", perf_stall_cyc, 32'(m_stall));
        check("perf_flush_cnt", 32'(perf_flush_cnt), 32'(m_flush));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
